// File: rtl/alu_pkg.sv
// Shared ALU definitions: serial adder state encoding and counter sizing helper.
package alu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Counter must reach WIDTH-1; never narrower than one bit.
   function automatic int cntWidth(input int w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/fulladder.sv
// Single-bit full adder, the one arithmetic cell time-shared by the serial engine.
module fulladder (
   input  logic i_a,
   input  logic i_b,
   input  logic i_cin,
   output logic o_sum,
   output logic o_cout
);

   assign o_sum  = i_a ^ i_b ^ i_cin;
   assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract: operands stream LSB-first through one full adder,
// one bit per clock, with the carry held in a flip-flop between bits.
module serial_add_ctrl
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carryout,
   output logic             overflow
);

   localparam int CNT_W = cntWidth(WIDTH);

   state_t             r_state;
   state_t             w_next;
   logic [WIDTH-1:0]   r_sa;
   logic [WIDTH-1:0]   r_sb;
   logic [WIDTH-1:0]   r_result;
   logic               r_carry;
   logic               r_carryout;
   logic               r_overflow;
   logic [CNT_W-1:0]   r_count;
   logic               w_sum;
   logic               w_cout;
   logic               w_last;

   fulladder u_fa (
      .i_a    (r_sa[0]),
      .i_b    (r_sb[0]),
      .i_cin  (r_carry),
      .o_sum  (w_sum),
      .o_cout (w_cout)
   );

   assign w_last = (r_count == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (start) w_next = RUN;
         RUN:     if (w_last) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Subtraction is a + ~b + 1: invert B at load and seed the carry with sub.
   // On the last bit r_carry is the carry into the MSB, so overflow is taken there.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sa       <= '0;
         r_sb       <= '0;
         r_result   <= '0;
         r_carry    <= 1'b0;
         r_carryout <= 1'b0;
         r_overflow <= 1'b0;
         r_count    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_sa     <= a;
                  r_sb     <= sub ? ~b : b;
                  r_carry  <= sub;
                  r_count  <= '0;
                  r_result <= '0;
               end
            end
            RUN: begin
               r_result <= {w_sum, r_result[WIDTH-1:1]};
               r_sa     <= r_sa >> 1;
               r_sb     <= r_sb >> 1;
               r_carry  <= w_cout;
               r_count  <= r_count + CNT_W'(1);
               if (w_last) begin
                  r_carryout <= w_cout;
                  r_overflow <= r_carry ^ w_cout;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy     = (r_state != IDLE);
   assign done     = (r_state == DONE);
   assign result   = r_result;
   assign carryout = r_carryout;
   assign overflow = r_overflow;

endmodule
